// File: rtl/fpu_mult_seq.sv
// Sequencer for the FP multiply path. It drives the shared mantissa multiplier,
// loads the normaliser, and holds the result until the consumer takes it.
// Optional macro FPU_MULT_SEQ_BYPASS_EN lets zero/inf/NaN operands skip the multiply.
module fpu_mult_seq #(
    parameter int MULT_LAT = 2,
    parameter int NORM_MAX = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_opa,
    input  logic [31:0] in_opb,
    input  logic        flush,
    output logic [23:0] mul_a,
    output logic [23:0] mul_b,
    output logic        mul_start,
    output logic [31:0] fpu_opa,
    output logic [31:0] fpu_opb,
    output logic        new_input,
    input  logic        fpu_mult_busy,
    input  logic [34:0] fpu_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [34:0] res,
    output logic        res_timeout
);

    localparam int CNT_MAX = (NORM_MAX > MULT_LAT) ? NORM_MAX : MULT_LAT;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] MUL_LAST  = CW'(MULT_LAT - 1);
    // The timeout fires after NORM_MAX busy samples, on the next NORM sample.
    localparam logic [CW-1:0] NORM_LAST = CW'(NORM_MAX);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_LOAD = 3'd2;
    localparam logic [2:0] S_NORM = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
`ifdef FPU_MULT_SEQ_BYPASS_EN
    localparam logic [2:0] S_CAPT = 3'd5;

    function automatic logic is_special(input logic [31:0] op);
        return ((op[30:23] == 8'h00) && (op[22:0] == 23'h0)) || (op[30:23] == 8'hFF);
    endfunction
`endif

    logic [2:0]    state;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            fpu_opa     <= '0;
            fpu_opb     <= '0;
            res         <= '0;
            res_timeout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        fpu_opa <= in_opa;
                        fpu_opb <= in_opb;
                        mul_a   <= {|in_opa[30:23], in_opa[22:0]};
                        mul_b   <= {|in_opb[30:23], in_opb[22:0]};
                        cnt     <= '0;
`ifdef FPU_MULT_SEQ_BYPASS_EN
                        state   <= (is_special(in_opa) || is_special(in_opb)) ? S_CAPT : S_MUL;
`else
                        state   <= S_MUL;
`endif
                    end
                end
                S_MUL: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else if (cnt == MUL_LAST) begin
                        state <= S_LOAD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                // Busy is not looked at here: the normaliser is only now being loaded.
                S_LOAD: begin
                    state <= flush ? S_IDLE : S_NORM;
                    cnt   <= '0;
                end
                S_NORM: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else if (!fpu_mult_busy) begin
                        res         <= fpu_out;
                        res_timeout <= 1'b0;
                        state       <= S_DONE;
                    end else if (cnt == NORM_LAST) begin
                        res         <= fpu_out;
                        res_timeout <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`ifdef FPU_MULT_SEQ_BYPASS_EN
                S_CAPT: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        res         <= fpu_out;
                        res_timeout <= 1'b0;
                        state       <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    if (out_ready || flush) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign mul_start = (state == S_MUL) && (cnt == '0);
    assign new_input = (state == S_LOAD);
    assign out_valid = (state == S_DONE);

endmodule

// File: tb/tb_fpu_mult_seq.sv
// Directed bench for fpu_mult_seq: latency, pulses, hold, timeout, flush and reset.
module tb_fpu_mult_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_opa;
    logic [31:0] in_opb;
    logic        flush;
    logic [23:0] mul_a;
    logic [23:0] mul_b;
    logic        mul_start;
    logic [31:0] fpu_opa;
    logic [31:0] fpu_opb;
    logic        new_input;
    logic        fpu_mult_busy;
    logic [34:0] fpu_out;
    logic        out_valid;
    logic        out_ready;
    logic [34:0] res;
    logic        res_timeout;

    int checks = 0;
    int errors = 0;

    fpu_mult_seq #(.MULT_LAT(2), .NORM_MAX(48)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_opa(in_opa), .in_opb(in_opb), .flush(flush),
        .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
        .fpu_opa(fpu_opa), .fpu_opb(fpu_opb), .new_input(new_input),
        .fpu_mult_busy(fpu_mult_busy), .fpu_out(fpu_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .res_timeout(res_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accepts one op and steps until out_valid; cycle c counts from the accept edge.
    // Busy is also raised in the LOAD cycle (c==3) to confirm it is ignored there.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int busy_n,
                          input logic [34:0] fout, output int lat_o, output int ms_c,
                          output int ni_c, output int ms_n, output int ni_n);
        int c;
        bit seen;
        lat_o = 0; ms_c = 0; ni_c = 0; ms_n = 0; ni_n = 0; seen = 0;
        fpu_out = fout;
        fpu_mult_busy = 1'b0;
        @(negedge clk);
        in_opa = a; in_opb = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        c = 1;
        while (!seen && c <= 120) begin
            if (mul_start) begin ms_n++; if (ms_c == 0) ms_c = c; end
            if (new_input) begin ni_n++; if (ni_c == 0) ni_c = c; end
            if (out_valid) begin
                seen = 1;
                lat_o = c;
                fpu_out = ~fout;
                fpu_mult_busy = 1'b0;
            end else begin
                fpu_mult_busy = (c == 3) || (c >= 4 && c < 4 + busy_n);
                c++;
                @(negedge clk);
            end
        end
    endtask

    task automatic finish_op(input string tag, input int hold, input logic [34:0] exp_res,
                             input logic exp_to);
        for (int h = 0; h < hold; h++) begin
            chk({tag, "_ov_hold"}, 35'(out_valid), 35'(1));
            chk({tag, "_res_hold"}, res, exp_res);
            chk({tag, "_to_hold"}, 35'(res_timeout), 35'(exp_to));
            chk({tag, "_inrdy_hold"}, 35'(in_ready), 35'(0));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_inrdy_after"}, 35'(in_ready), 35'(1));
        chk({tag, "_ov_after"}, 35'(out_valid), 35'(0));
    endtask

    int lat, ms_cyc, ni_cyc, ms_cnt, ni_cnt, extra;
    logic [34:0] exp_res;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_opa = '0; in_opb = '0; flush = 1'b0;
        fpu_mult_busy = 1'b0; fpu_out = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 35'(in_ready), 35'(1));
        chk("rst_out_valid", 35'(out_valid), 35'(0));
        chk("rst_mul_start", 35'(mul_start), 35'(0));
        chk("rst_res", res, 35'(0));
        rst = 1'b0;

        // 1.5 * 1.5, normaliser done at first sample
        exp_res = 35'h1_2345_6789;
        run_op(32'h3FC00000, 32'h3FC00000, 0, exp_res, lat, ms_cyc, ni_cyc, ms_cnt, ni_cnt);
        chk("t1_lat", 35'(lat), 35'(5));
        chk("t1_ms_cyc", 35'(ms_cyc), 35'(1));
        chk("t1_ni_cyc", 35'(ni_cyc), 35'(3));
        chk("t1_ms_cnt", 35'(ms_cnt), 35'(1));
        chk("t1_ni_cnt", 35'(ni_cnt), 35'(1));
        chk("t1_mul_a", 35'(mul_a), 35'(24'hC00000));
        chk("t1_mul_b", 35'(mul_b), 35'(24'hC00000));
        chk("t1_fpu_opa", 35'(fpu_opa), 35'(32'h3FC00000));
        finish_op("t1", 1, exp_res, 1'b0);

        // 1.0 * 1.0, one busy cycle, consumer stalls 4 cycles while a new request waits
        exp_res = 35'h4_0F0F_1234;
        run_op(32'h3F800000, 32'h3F800000, 1, exp_res, lat, ms_cyc, ni_cyc, ms_cnt, ni_cnt);
        chk("t2_lat", 35'(lat), 35'(6));
        chk("t2_mul_a", 35'(mul_a), 35'(24'h800000));
        in_opa = 32'h40000000; in_opb = 32'h40000000; in_valid = 1'b1;
        for (int h = 0; h < 4; h++) begin
            chk("t2_res_stall", res, exp_res);
            chk("t2_inrdy_stall", 35'(in_ready), 35'(0));
            chk("t2_opa_stall", 35'(fpu_opa), 35'(32'h3F800000));
            @(negedge clk);
        end
        in_valid = 1'b0;
        finish_op("t2", 1, exp_res, 1'b0);

        // busy stuck high: timeout capture
        exp_res = 35'h2_AAAA_5555;
        run_op(32'h3FC00000, 32'h3F800000, 1000, exp_res, lat, ms_cyc, ni_cyc, ms_cnt, ni_cnt);
        chk("t3_lat", 35'(lat), 35'(53));
        chk("t3_res", res, exp_res);
        chk("t3_timeout", 35'(res_timeout), 35'(1));
        finish_op("t3", 2, exp_res, 1'b1);

        // flush in the second MUL cycle
        @(negedge clk);
        in_opa = 32'h3FC00000; in_opb = 32'h3FC00000; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("t4_ms_first", 35'(mul_start), 35'(1));
        @(negedge clk);
        chk("t4_ms_second", 35'(mul_start), 35'(0));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("t4_idle", 35'(in_ready), 35'(1));
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            if (new_input || out_valid || mul_start) extra++;
            @(negedge clk);
        end
        chk("t4_no_pulses", 35'(extra), 35'(0));
        exp_res = 35'h0_7654_3210;
        run_op(32'h3FC00000, 32'h3FC00000, 0, exp_res, lat, ms_cyc, ni_cyc, ms_cnt, ni_cnt);
        chk("t4_next_lat", 35'(lat), 35'(5));
        chk("t4_next_ni_cnt", 35'(ni_cnt), 35'(1));
        finish_op("t4", 1, exp_res, 1'b0);

        // flush while DONE drops the held result
        run_op(32'h3F800000, 32'h3FC00000, 0, 35'h1_1111_1111, lat, ms_cyc, ni_cyc, ms_cnt, ni_cnt);
        chk("t4d_lat", 35'(lat), 35'(5));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("t4d_ov", 35'(out_valid), 35'(0));
        chk("t4d_inrdy", 35'(in_ready), 35'(1));

        // reset while in NORM
        fpu_out = 35'h3_3333_3333;
        fpu_mult_busy = 1'b1;
        @(negedge clk);
        in_opa = 32'h3FC00000; in_opb = 32'h3FC00000; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_pre_inrdy", 35'(in_ready), 35'(0));
        rst = 1'b1;
        #1;
        chk("t5_inrdy", 35'(in_ready), 35'(1));
        chk("t5_mul_a", 35'(mul_a), 35'(0));
        chk("t5_mul_b", 35'(mul_b), 35'(0));
        chk("t5_fpu_opa", 35'(fpu_opa), 35'(0));
        chk("t5_fpu_opb", 35'(fpu_opb), 35'(0));
        chk("t5_res", res, 35'(0));
        chk("t5_to", 35'(res_timeout), 35'(0));
        chk("t5_ov", 35'(out_valid), 35'(0));
        chk("t5_pulses", 35'({mul_start, new_input}), 35'(0));
        @(negedge clk);
        rst = 1'b0;
        fpu_mult_busy = 1'b0;
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) extra++;
            @(negedge clk);
        end
        chk("t5_no_ov", 35'(extra), 35'(0));

        // zero operand
        run_op(32'h00000000, 32'h40400000, 0, 35'h0, lat, ms_cyc, ni_cyc, ms_cnt, ni_cnt);
`ifdef FPU_MULT_SEQ_BYPASS_EN
        chk("t6_lat", 35'(lat), 35'(2));
        chk("t6_ms_cnt", 35'(ms_cnt), 35'(0));
        chk("t6_ni_cnt", 35'(ni_cnt), 35'(0));
`else
        chk("t6_lat", 35'(lat), 35'(5));
        chk("t6_ms_cnt", 35'(ms_cnt), 35'(1));
        chk("t6_ni_cnt", 35'(ni_cnt), 35'(1));
`endif
        chk("t6_mul_a", 35'(mul_a), 35'(0));
        chk("t6_mul_b", 35'(mul_b), 35'(24'hC00000));
        finish_op("t6", 1, 35'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
